// File: rtl/lap_timer.sv
// lap_timer: N-digit BCD up/down timer with preload, countdown expiry and lap
// capture. Buttons are active-low asynchronous pins; each is synchronised and
// turned into a one-cycle event pulse on its falling edge.
//
// Optional feature macro: LAP_TIMER_LAP_EN
//   defined     : lap button captures the running count into lap_digits
//   not defined : lap input unused, lap_digits mirrors digits
//
// Handshake note: there is no valid/ready pair here. load_en is a one-cycle
// strobe that is acted on only in STOP; button events are one-cycle pulses that
// each state either consumes or ignores, and nothing is queued.
module lap_timer #(
    parameter int          TICK_DIV = 960000,
    parameter int          N_DIGITS = 6,
    parameter logic [7:0]  WRAP6    = 8'h28
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  start_stop,
    input  logic                  clear,
    input  logic                  lap,
    input  logic                  count_down,
    input  logic                  load_en,
    input  logic [4*N_DIGITS-1:0] load_val,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [4*N_DIGITS-1:0] lap_digits,
    output logic                  running,
    output logic                  expired,
    output logic                  ovf
);

    localparam int W  = 4 * N_DIGITS;
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STOP = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state;
    logic [2:0]      ss_sync;
    logic [2:0]      clr_sync;
    logic            ss_ev;
    logic            clr_ev;
    logic [PW-1:0]   presc;
    logic            tick;
    logic [W-1:0]    up_val;
    logic [W-1:0]    dn_val;
    logic [W-1:0]    load_sat;
    logic [W-1:0]    tick_val;
    logic            all_max;
    logic            all_zero;
    logic            dn_zero;

    // Button synchronisers: bits [1:0] are the 2-FF chain, bit 2 holds the previous
    // synchronised level; the event is registered, so it appears 3 clk after the fall.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ss_sync  <= 3'b111;
            clr_sync <= 3'b111;
            ss_ev    <= 1'b0;
            clr_ev   <= 1'b0;
        end else begin
            ss_sync  <= {ss_sync[1:0], start_stop};
            clr_sync <= {clr_sync[1:0], clear};
            ss_ev    <= ss_sync[2] & ~ss_sync[1];
            clr_ev   <= clr_sync[2] & ~clr_sync[1];
        end
    end

    // Prescaler advances only while running, holds when stopped or expired, and
    // restarts from zero whenever the timer passes through IDLE.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= (state == RUN) && (presc == PW'(TICK_DIV - 1));
            if (state == IDLE) begin
                presc <= '0;
            end else if (state == RUN) begin
                presc <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + 1'b1;
            end
        end
    end

    // Carry and borrow chains across all digits plus load-value saturation.
    always_comb begin
        logic       carry;
        logic       borrow;
        logic [3:0] d;
        logic [3:0] mx;
        logic [3:0] lv;
        carry    = 1'b1;
        borrow   = 1'b1;
        up_val   = '0;
        dn_val   = '0;
        load_sat = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            d  = digits[4*k +: 4];
            mx = WRAP6[k] ? 4'd5 : 4'd9;
            lv = load_val[4*k +: 4];
            if (carry && (d >= mx)) begin
                up_val[4*k +: 4] = 4'd0;
            end else if (carry) begin
                up_val[4*k +: 4] = d + 4'd1;
                carry            = 1'b0;
            end else begin
                up_val[4*k +: 4] = d;
            end
            if (borrow && (d == 4'd0)) begin
                dn_val[4*k +: 4] = mx;
            end else if (borrow) begin
                dn_val[4*k +: 4] = d - 4'd1;
                borrow           = 1'b0;
            end else begin
                dn_val[4*k +: 4] = d;
            end
            load_sat[4*k +: 4] = (lv > mx) ? mx : lv;
        end
        all_max = carry;
    end

    assign all_zero = (digits == '0);
    assign dn_zero  = (dn_val == '0);

    // Count value after this cycle's tick; a down tick from zero never underflows.
    assign tick_val = !tick      ? digits :
                      count_down ? (all_zero ? digits : dn_val) :
                                   up_val;

    // Main FSM. Expiry outranks a coincident start/stop event; otherwise a tick
    // landing together with start/stop is applied before stopping.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state   <= IDLE;
            digits  <= '0;
            running <= 1'b0;
            expired <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            ovf <= 1'b0;
            case (state)
                IDLE: begin
                    digits  <= '0;
                    running <= 1'b0;
                    expired <= 1'b0;
                    state   <= STOP;
                end
                STOP: begin
                    if (ss_ev) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end else if (clr_ev) begin
                        state <= IDLE;
                    end else if (load_en) begin
                        digits <= load_sat;
                    end
                end
                RUN: begin
                    if (tick && count_down && (all_zero || dn_zero)) begin
                        state   <= DONE;
                        running <= 1'b0;
                        expired <= 1'b1;
                        digits  <= '0;
                    end else begin
                        digits <= tick_val;
                        if (tick && !count_down && all_max) begin
                            ovf <= 1'b1;
                        end
                        if (ss_ev) begin
                            state   <= STOP;
                            running <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    if (clr_ev) begin
                        state   <= IDLE;
                        expired <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                    expired <= 1'b0;
                end
            endcase
        end
    end

`ifdef LAP_TIMER_LAP_EN
    logic [2:0] lap_sync;
    logic       lap_ev;

    // Lap button synchroniser, same structure as the other buttons.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            lap_sync <= 3'b111;
            lap_ev   <= 1'b0;
        end else begin
            lap_sync <= {lap_sync[1:0], lap};
            lap_ev   <= lap_sync[2] & ~lap_sync[1];
        end
    end

    // Lap capture while running takes the post-tick value; IDLE wipes the capture.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            lap_digits <= '0;
        end else if (state == IDLE) begin
            lap_digits <= '0;
        end else if ((state == RUN) && lap_ev) begin
            lap_digits <= tick_val;
        end
    end
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign lap_digits = digits;
`endif

endmodule
